pip_check: RTL and testbench

PIP_CHECK -- requirements
Module: pip_check

---
 rtl/pip_check.sv | 173 +++++++++++++++++
 tb/tb_pip_check.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pip_check.sv
// ---------------------------------------------------------------------------
// pip_check -- prediction-in-pipeline checker
//
// Fetch pushes {pc, predicted next pc} records into a small in-order FIFO.
// Execute later presents the resolved {pc, correct next pc} of the oldest
// in-flight control-flow instruction. Each resolved record pops the FIFO head
// and is compared against it. On a mismatch the block issues a registered
// redirect to fetch, pulses flush for one cycle, empties the FIFO and waits in
// REDIR until fetch acknowledges the redirect.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous reset, active low
//   pred_valid / pred_ready / pred_pc / pred_npc   prediction push handshake
//   res_valid  / res_ready  / res_pc  / res_npc    resolved outcome handshake
//   redir_valid / redir_pc / redir_ack             redirect request to fetch
//   flush        one-cycle pulse accompanying a new redirect
//   sync_err     sticky: a resolved pc did not match the queued pc
//   fifo_cnt     FIFO occupancy
//   branch_cnt   resolved records consumed (saturating)
//   mispred_cnt  mispredictions detected (saturating)
// ---------------------------------------------------------------------------
module pip_check #(
  parameter int DEPTH = 4,
  parameter int PCW   = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pred_valid,
  output logic            pred_ready,
  input  logic [PCW-1:0]  pred_pc,
  input  logic [PCW-1:0]  pred_npc,
  input  logic            res_valid,
  output logic            res_ready,
  input  logic [PCW-1:0]  res_pc,
  input  logic [PCW-1:0]  res_npc,
  output logic            redir_valid,
  output logic [PCW-1:0] redir_pc,
  input  logic            redir_ack,
  output logic            flush,
  output logic            sync_err,
  output logic [4:0]      fifo_cnt,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } state_t;

  state_t           state_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [4:0]       cnt_reg;
  logic             redir_valid_reg;
  logic [PCW-1:0]   redir_pc_reg;
  logic             flush_reg;
  logic             sync_err_reg;
  logic [31:0]      branch_cnt_reg;
  logic [31:0]      mispred_cnt_reg;

  // Record storage; no reset needed, occupancy is tracked by the pointers.
  logic [PCW-1:0]   pc_mem  [DEPTH];
  logic [PCW-1:0]   npc_mem [DEPTH];

  logic             in_run;
  logic             push;
  logic             pop;
  logic [PCW-1:0]   head_pc;
  logic [PCW-1:0]   head_npc;
  logic             pc_miss;
  logic             npc_miss;
  logic             mispredict;

  // Readies are forced low while reset is held.
  assign in_run     = rst && (state_reg == RUN);
  assign pred_ready = in_run && (cnt_reg < 5'(DEPTH));
  assign res_ready  = in_run && (cnt_reg != 5'd0);
  assign push       = pred_valid && pred_ready;
  assign pop        = res_valid && res_ready;

  // The head must be visible in the pop cycle so the comparison and the
  // redirect can be registered on the same edge (one-cycle redirect latency).
  assign head_pc    = pc_mem[rd_ptr_reg];
  assign head_npc   = npc_mem[rd_ptr_reg];
  assign pc_miss    = pop && (head_pc != res_pc);
  assign npc_miss   = pop && (head_npc != res_npc);
  assign mispredict = pc_miss || npc_miss;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // A push coinciding with a mispredicting pop is discarded along with the
  // rest of the queue, so it is not written either.
  always_ff @(posedge clk) begin
    if (push && !mispredict) begin
      pc_mem[wr_ptr_reg]  <= pred_pc;
      npc_mem[wr_ptr_reg] <= pred_npc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= RUN;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      cnt_reg         <= 5'd0;
      redir_valid_reg <= 1'b0;
      redir_pc_reg    <= '0;
      flush_reg       <= 1'b0;
      sync_err_reg    <= 1'b0;
      branch_cnt_reg  <= 32'd0;
      mispred_cnt_reg <= 32'd0;
    end else begin
      flush_reg <= 1'b0;
      case (state_reg)
        RUN: begin
          if (pop) begin
            branch_cnt_reg <= sat_inc(branch_cnt_reg);
          end
          if (mispredict) begin
            mispred_cnt_reg <= sat_inc(mispred_cnt_reg);
            redir_valid_reg <= 1'b1;
            redir_pc_reg    <= res_npc;
            flush_reg       <= 1'b1;
            state_reg       <= REDIR;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            cnt_reg         <= 5'd0;
            if (pc_miss) begin
              sync_err_reg <= 1'b1;
            end
          end else begin
            // Pointers are AW bits wide and DEPTH is a power of two, so the
            // natural overflow gives the modulo-DEPTH wrap.
            if (push) begin
              wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
              rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
              2'b10:   cnt_reg <= cnt_reg + 5'd1;
              2'b01:   cnt_reg <= cnt_reg - 5'd1;
              default: cnt_reg <= cnt_reg;
            endcase
          end
        end
        REDIR: begin
          // redir_pc stays put; only the ack releases the request.
          if (redir_ack) begin
            redir_valid_reg <= 1'b0;
            state_reg       <= RUN;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign redir_valid = redir_valid_reg;
  assign redir_pc    = redir_pc_reg;
  assign flush       = flush_reg;
  assign sync_err    = sync_err_reg;
  assign fifo_cnt    = cnt_reg;
  assign branch_cnt  = branch_cnt_reg;
  assign mispred_cnt = mispred_cnt_reg;

endmodule

// File: tb/tb_pip_check.sv
// ---------------------------------------------------------------------------
// tb_pip_check -- self-checking bench for pip_check.
// Directed scenarios followed by randomized traffic compared against a
// queue-based reference model of the prediction checker.
// ---------------------------------------------------------------------------
module tb_pip_check;
  localparam int DEPTH = 4;
  localparam int PCW   = 64;

  logic            clk;
  logic            rst;
  logic            pred_valid;
  logic            pred_ready;
  logic [PCW-1:0]  pred_pc;
  logic [PCW-1:0]  pred_npc;
  logic            res_valid;
  logic            res_ready;
  logic [PCW-1:0]  res_pc;
  logic [PCW-1:0]  res_npc;
  logic            redir_valid;
  logic [PCW-1:0]  redir_pc;
  logic            redir_ack;
  logic            flush;
  logic            sync_err;
  logic [4:0]      fifo_cnt;
  logic [31:0]     branch_cnt;
  logic [31:0]     mispred_cnt;

  int checks = 0;
  int errors = 0;

  pip_check #(.DEPTH(DEPTH), .PCW(PCW)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_ready(pred_ready),
    .pred_pc(pred_pc), .pred_npc(pred_npc),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_pc(res_pc), .res_npc(res_npc),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ack(redir_ack),
    .flush(flush), .sync_err(sync_err), .fifo_cnt(fifo_cnt),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [PCW-1:0] pc;
    logic [PCW-1:0] npc;
  } rec_t;

  rec_t           mq[$];
  bit             m_redir;
  logic [PCW-1:0] m_rpc;
  bit             m_flush;
  bit             m_sync;
  logic [31:0]    m_br;
  logic [31:0]    m_mis;

  function automatic bit m_pred_ready();
    return rst && !m_redir && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_res_ready();
    return rst && !m_redir && (mq.size() > 0);
  endfunction

  // Advance the model with the inputs present at the coming edge, then step
  // the clock and leave time 1 unit after the edge.
  task automatic tick();
    bit   do_push, do_pop, bad;
    rec_t h;
    if (!rst) begin
      mq.delete();
      m_redir = 0; m_rpc = '0; m_flush = 0; m_sync = 0; m_br = 0; m_mis = 0;
    end else begin
      m_flush = 0;
      if (m_redir) begin
        if (redir_ack) m_redir = 0;
      end else begin
        do_push = pred_valid && (mq.size() < DEPTH);
        do_pop  = res_valid && (mq.size() > 0);
        bad     = 0;
        if (do_pop) begin
          h   = mq[0];
          bad = (h.pc != res_pc) || (h.npc != res_npc);
          if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
          if (bad) begin
            if (m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
            m_redir = 1; m_rpc = res_npc; m_flush = 1;
            if (h.pc != res_pc) m_sync = 1;
            mq.delete();
          end else begin
            void'(mq.pop_front());
          end
        end
        if (do_push && !bad) mq.push_back('{pred_pc, pred_npc});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    pred_valid = 0; res_valid = 0; redir_ack = 0;
    pred_pc = '0; pred_npc = '0; res_pc = '0; res_npc = '0;
  endtask

  task automatic push_rec(input logic [PCW-1:0] pc, input logic [PCW-1:0] npc);
    pred_valid = 1; pred_pc = pc; pred_npc = npc;
    tick();
    pred_valid = 0;
    $display("push pc=%h npc=%h cnt=%0d", pc, npc, fifo_cnt);
  endtask

  task automatic resolve(input logic [PCW-1:0] pc, input logic [PCW-1:0] npc);
    res_valid = 1; res_pc = pc; res_npc = npc;
    tick();
    res_valid = 0;
    $display("resolve pc=%h npc=%h redir=%0b cnt=%0d", pc, npc, redir_valid, fifo_cnt);
  endtask

  task automatic ack_redirect();
    redir_ack = 1;
    tick();
    redir_ack = 0;
    $display("redirect acked redir_valid=%0b", redir_valid);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    rst = 0;
    tick();
    tick();
    checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL reset_pred_ready got %0b exp 0", pred_ready); end
    checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL reset_res_ready got %0b exp 0", res_ready); end
    checks++; if (fifo_cnt !== 5'd0) begin errors++; $display("FAIL reset_fifo_cnt got %0d exp 0", fifo_cnt); end
    checks++; if (redir_valid !== 1'b0 || flush !== 1'b0 || sync_err !== 1'b0 || redir_pc !== '0) begin
      errors++; $display("FAIL reset_flags got rv=%0b fl=%0b se=%0b rpc=%h exp all 0", redir_valid, flush, sync_err, redir_pc); end
    checks++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", branch_cnt, mispred_cnt); end
    rst = 1;
    #1;
    checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL reset_release_pred_ready got %0b exp 1", pred_ready); end
    $display("reset done");
  endtask

  task automatic test_hit();
    bit flush_seen;
    push_rec(64'h8000_0000, 64'h8000_0004);
    checks++; if (fifo_cnt !== 5'd1) begin errors++; $display("FAIL hit_cnt_after_push got %0d exp 1", fifo_cnt); end
    res_valid = 1; res_pc = 64'h8000_0000; res_npc = 64'h8000_0004;
    #1;
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL hit_res_ready got %0b exp 1", res_ready); end
    tick();
    res_valid = 0;
    flush_seen = flush;
    tick();
    flush_seen = flush_seen | flush;
    $display("hit resolved cnt=%0d branches=%0d", fifo_cnt, branch_cnt);
    checks++; if (redir_valid !== 1'b0 || flush_seen) begin errors++; $display("FAIL hit_no_redirect got rv=%0b flush_seen=%0b exp 0/0", redir_valid, flush_seen); end
    checks++; if (branch_cnt !== 32'd1 || mispred_cnt !== 32'd0) begin errors++; $display("FAIL hit_counters got %0d/%0d exp 1/0", branch_cnt, mispred_cnt); end
    checks++; if (fifo_cnt !== 5'd0) begin errors++; $display("FAIL hit_cnt got %0d exp 0", fifo_cnt); end
  endtask

  task automatic test_mispredict();
    push_rec(64'h8000_0010, 64'h8000_0100);
    resolve(64'h8000_0010, 64'h8000_0014);
    checks++; if (redir_valid !== 1'b1 || redir_pc !== 64'h8000_0014) begin
      errors++; $display("FAIL mis_redirect got rv=%0b rpc=%h exp 1/8000_0014", redir_valid, redir_pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mis_flush_pulse got %0b exp 1", flush); end
    checks++; if (mispred_cnt !== 32'd1 || branch_cnt !== 32'd2) begin
      errors++; $display("FAIL mis_counters got %0d/%0d exp 2/1", branch_cnt, mispred_cnt); end
    for (int i = 0; i < 5; i++) begin
      pred_valid = 1; res_valid = 1; pred_pc = 64'hDEAD; res_npc = 64'hBEEF;
      #1;
      checks++; if (pred_ready !== 1'b0 || res_ready !== 1'b0) begin
        errors++; $display("FAIL mis_hold_ready cyc %0d got %0b/%0b exp 0/0", i, pred_ready, res_ready); end
      tick();
      checks++; if (redir_valid !== 1'b1 || redir_pc !== 64'h8000_0014 || flush !== 1'b0) begin
        errors++; $display("FAIL mis_hold cyc %0d got rv=%0b rpc=%h fl=%0b exp 1/8000_0014/0", i, redir_valid, redir_pc, flush); end
    end
    drive_idle();
    ack_redirect();
    checks++; if (redir_valid !== 1'b0 || pred_ready !== 1'b1) begin
      errors++; $display("FAIL mis_ack got rv=%0b pr=%0b exp 0/1", redir_valid, pred_ready); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] br_before;
    br_before = branch_cnt;
    for (int i = 0; i < DEPTH; i++) push_rec(64'h1000 + 64'(i * 16), 64'h2000 + 64'(i * 16));
    #1;
    checks++; if (pred_ready !== 1'b0 || fifo_cnt !== 5'(DEPTH)) begin
      errors++; $display("FAIL full_ready got pr=%0b cnt=%0d exp 0/%0d", pred_ready, fifo_cnt, DEPTH); end
    resolve(mq[0].pc, mq[0].npc);
    for (int i = 0; i < 6; i++) begin
      pred_valid = 1; pred_pc = 64'h3000 + 64'(i); pred_npc = 64'h4000 + 64'(i);
      res_valid = 1; res_pc = mq[0].pc; res_npc = mq[0].npc;
      tick();
      drive_idle();
      $display("push+pop %0d cnt=%0d redir=%0b", i, fifo_cnt, redir_valid);
      checks++; if (fifo_cnt !== 5'(DEPTH - 1) || redir_valid !== 1'b0) begin
        errors++; $display("FAIL wrap_pushpop %0d got cnt=%0d rv=%0b exp %0d/0", i, fifo_cnt, redir_valid, DEPTH - 1); end
    end
    while (mq.size() > 0) resolve(mq[0].pc, mq[0].npc);
    checks++; if (branch_cnt !== br_before + 32'd10 || mispred_cnt !== 32'd1 || redir_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_order got br=%0d mis=%0d rv=%0b exp %0d/1/0", branch_cnt, mispred_cnt, redir_valid, br_before + 10); end
  endtask

  task automatic test_flush_push();
    logic [PCW-1:0] bad_npc;
    for (int i = 0; i < 3; i++) push_rec(64'h5000 + 64'(i * 8), 64'h6000 + 64'(i * 8));
    resolve(mq[0].pc, mq[0].npc);
    bad_npc = mq[0].npc ^ 64'h1;
    pred_valid = 1; pred_pc = 64'h7777; pred_npc = 64'h8888;
    res_valid = 1; res_pc = mq[0].pc; res_npc = bad_npc;
    tick();
    drive_idle();
    $display("mispredict with push cnt=%0d redir=%0b", fifo_cnt, redir_valid);
    checks++; if (fifo_cnt !== 5'd0 || redir_valid !== 1'b1 || redir_pc !== bad_npc || flush !== 1'b1) begin
      errors++; $display("FAIL flush_push got cnt=%0d rv=%0b rpc=%h fl=%0b exp 0/1/%h/1", fifo_cnt, redir_valid, redir_pc, flush, bad_npc); end
    ack_redirect();
    #1;
    checks++; if (fifo_cnt !== 5'd0 || res_ready !== 1'b0 || pred_ready !== 1'b1) begin
      errors++; $display("FAIL flush_dropped got cnt=%0d rr=%0b pr=%0b exp 0/0/1", fifo_cnt, res_ready, pred_ready); end
  endtask

  task automatic test_sync_err();
    push_rec(64'h100, 64'h104);
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_pre got %0b exp 0", sync_err); end
    resolve(64'h104, 64'h200);
    checks++; if (sync_err !== 1'b1 || redir_valid !== 1'b1 || redir_pc !== 64'h200) begin
      errors++; $display("FAIL sync_set got se=%0b rv=%0b rpc=%h exp 1/1/200", sync_err, redir_valid, redir_pc); end
    ack_redirect();
    push_rec(64'h200, 64'h204);
    resolve(64'h200, 64'h204);
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_sticky got %0b exp 1", sync_err); end
  endtask

  task automatic test_reset_mid();
    push_rec(64'hA0, 64'hA4);
    push_rec(64'hB0, 64'hB4);
    rst = 0;
    tick();
    checks++; if (fifo_cnt !== 5'd0 || branch_cnt !== 32'd0 || mispred_cnt !== 32'd0 || sync_err !== 1'b0) begin
      errors++; $display("FAIL rst_queue got cnt=%0d br=%0d mis=%0d se=%0b exp 0/0/0/0", fifo_cnt, branch_cnt, mispred_cnt, sync_err); end
    rst = 1;
    for (int i = 0; i < 3; i++) push_rec(64'hC0 + 64'(i * 4), 64'hD0 + 64'(i * 4));
    resolve(64'hC0, 64'hFFF0);
    checks++; if (redir_valid !== 1'b1) begin errors++; $display("FAIL rst_redir_setup got %0b exp 1", redir_valid); end
    rst = 0; pred_valid = 1; pred_pc = 64'hE0; pred_npc = 64'hE4;
    tick();
    drive_idle();
    checks++; if (redir_valid !== 1'b0 || flush !== 1'b0 || fifo_cnt !== 5'd0 || redir_pc !== '0) begin
      errors++; $display("FAIL rst_redir got rv=%0b fl=%0b cnt=%0d rpc=%h exp 0/0/0/0", redir_valid, flush, fifo_cnt, redir_pc); end
    checks++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_redir_counters got %0d/%0d exp 0/0", branch_cnt, mispred_cnt); end
    rst = 1;
    tick();
    checks++; if (pred_ready !== 1'b1 || flush !== 1'b0) begin
      errors++; $display("FAIL rst_back_to_run got pr=%0b fl=%0b exp 1/0", pred_ready, flush); end
    $display("reset in redirect done");
  endtask

  task automatic test_random();
    int mode;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst        = ($urandom_range(0, 199) != 0);
      pred_valid = $urandom_range(0, 1);
      pred_pc    = {$urandom(), $urandom()};
      pred_npc   = {$urandom(), $urandom()};
      res_valid  = ($urandom_range(0, 2) != 0);
      redir_ack  = m_redir ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
      mode       = $urandom_range(0, 9);
      if (mq.size() > 0 && mode < 9) begin
        res_pc  = (mode == 8) ? mq[0].pc + 64'h4 : mq[0].pc;
        res_npc = (mode == 7) ? ~mq[0].npc : mq[0].npc;
      end else begin
        res_pc  = {$urandom(), $urandom()};
        res_npc = {$urandom(), $urandom()};
      end
      #1;
      checks++; if (pred_ready !== m_pred_ready() || res_ready !== m_res_ready()) begin
        errors++; $display("FAIL rand_ready cyc %0d got %0b/%0b exp %0b/%0b", cyc, pred_ready, res_ready, m_pred_ready(), m_res_ready()); end
      if (res_valid && m_res_ready())
        $display("rand txn %0d pop pc=%h npc=%h head_pc=%h head_npc=%h", cyc, res_pc, res_npc, mq[0].pc, mq[0].npc);
      tick();
      checks++; if (fifo_cnt !== 5'(mq.size()) || redir_valid !== m_redir || flush !== m_flush || sync_err !== m_sync) begin
        errors++; $display("FAIL rand_state cyc %0d got cnt=%0d rv=%0b fl=%0b se=%0b exp %0d/%0b/%0b/%0b",
                           cyc, fifo_cnt, redir_valid, flush, sync_err, mq.size(), m_redir, m_flush, m_sync); end
      checks++; if (branch_cnt !== m_br || mispred_cnt !== m_mis || (m_redir && redir_pc !== m_rpc)) begin
        errors++; $display("FAIL rand_counters cyc %0d got br=%0d mis=%0d rpc=%h exp %0d/%0d/%h",
                           cyc, branch_cnt, mispred_cnt, redir_pc, m_br, m_mis, m_rpc); end
    end
    drive_idle();
    rst = 1;
  endtask

  initial begin
    rst = 0;
    drive_idle();
    mq.delete();
    m_redir = 0; m_rpc = '0; m_flush = 0; m_sync = 0; m_br = 0; m_mis = 0;
    test_reset();
    test_hit();
    test_mispredict();
    test_full_wrap();
    test_flush_push();
    test_sync_err();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
